puzzle_loader: RTL and testbench

//  Sequences the byte stream from the UART receiver into a nonogram puzzle load.
//  - Frames and validates a packet; writes clue bytes to the clue RAM write port.
//  - Commits the puzzle dimensions; signals done or error to the solver top level.
//  - Sits between uart_rx (axiov/axiod) and the clue memory / solver start logic.

---
 rtl/puzzle_loader.sv | 201 ++++++++++++++++++++
 tb/tb_puzzle_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_loader.sv
// Frames the uart_rx byte stream into a nonogram puzzle load: header checks, clue RAM writes, checksum, commit.
// Optional inter-byte timeout abort is enabled by defining PUZZLE_LOADER_TIMEOUT_EN.
module puzzle_loader #(
   parameter  int MAX_DIM     = 15,
   parameter  int MAX_CLUES   = 256,
   parameter  int TIMEOUT_CYC = 104160,
   localparam int ADDR_W      = $clog2(MAX_CLUES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              solver_rdy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic [7:0]        rows,
   output logic [7:0]        cols,
   output logic [ADDR_W:0]   clue_cnt,
   output logic              busy,
   output logic              load_done,
   output logic              load_err,
   output logic [1:0]        err_code
);

   typedef enum logic [3:0] {
      S_IDLE, S_ROWS, S_COLS, S_LEN_HI, S_LEN_LO, S_CLUES, S_CSUM, S_DONE, S_ERR
   } state_t;

   localparam logic [7:0]  MAX_DIM_B   = 8'(MAX_DIM);
   localparam logic [16:0] MAX_CLUES_L = 17'(MAX_CLUES);

   state_t            state_q, state_d;
   logic [7:0]        rows_sh_q, rows_sh_d, cols_sh_q, cols_sh_d;
   logic [7:0]        sum_q, sum_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic [7:0]        rows_q, rows_d, cols_q, cols_d;
   logic [ADDR_W:0]   clue_cnt_q, clue_cnt_d;
   logic              busy_q, busy_d;
   logic              load_done_q, load_done_d;
   logic              load_err_q, load_err_d;
   logic [1:0]        err_code_q, err_code_d;

   logic              dim_bad, len_bad, clue_last, timeout_hit;
   logic [15:0]       len_new;
   logic [ADDR_W:0]   cnt_inc;

   assign dim_bad   = (rx_data == 8'd0) || (rx_data > MAX_DIM_B);
   assign len_new   = {len_q[15:8], rx_data};
   assign len_bad   = (len_new == 16'd0) || ({1'b0, len_new} > MAX_CLUES_L);
   assign cnt_inc   = cnt_q + 1'b1;
   assign clue_last = (16'(cnt_inc) == len_q);

`ifdef PUZZLE_LOADER_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             tmr_run;

   // Only the byte-collecting states can time out; DONE/ERR leave on their own.
   assign tmr_run     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
   assign tmr_d       = (!tmr_run || rx_valid) ? '0 : tmr_q + 1'b1;
   assign timeout_hit = tmr_run && !rx_valid && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) tmr_q <= '0;
      else     tmr_q <= tmr_d;
   end
`else
   assign timeout_hit = 1'b0;
   if (TIMEOUT_CYC < 1) begin : g_timeout_param_illegal
   end
`endif

   always_comb begin
      state_d     = state_q;
      rows_sh_d   = rows_sh_q;
      cols_sh_d   = cols_sh_q;
      sum_d       = sum_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rows_d      = rows_q;
      cols_d      = cols_q;
      clue_cnt_d  = clue_cnt_q;
      load_done_d = 1'b0;
      load_err_d  = 1'b0;
      err_code_d  = 2'd0;
      case (state_q)
         S_IDLE: if (rx_valid && rx_data == 8'hA5 && solver_rdy) begin
            state_d = S_ROWS;
            sum_d   = 8'd0;
         end
         S_ROWS: if (rx_valid) begin
            if (dim_bad) begin
               state_d = S_ERR; load_err_d = 1'b1; err_code_d = 2'd1;
            end else begin
               rows_sh_d = rx_data; sum_d = sum_q + rx_data; state_d = S_COLS;
            end
         end
         S_COLS: if (rx_valid) begin
            if (dim_bad) begin
               state_d = S_ERR; load_err_d = 1'b1; err_code_d = 2'd1;
            end else begin
               cols_sh_d = rx_data; sum_d = sum_q + rx_data; state_d = S_LEN_HI;
            end
         end
         S_LEN_HI: if (rx_valid) begin
            len_d   = {rx_data, 8'h00};
            sum_d   = sum_q + rx_data;
            state_d = S_LEN_LO;
         end
         S_LEN_LO: if (rx_valid) begin
            if (len_bad) begin
               state_d = S_ERR; load_err_d = 1'b1; err_code_d = 2'd2;
            end else begin
               len_d = len_new; sum_d = sum_q + rx_data; cnt_d = '0; state_d = S_CLUES;
            end
         end
         S_CLUES: if (rx_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q[ADDR_W-1:0];
            mem_wdata_d = rx_data;
            sum_d       = sum_q + rx_data;
            cnt_d       = cnt_inc;
            if (clue_last) state_d = S_CSUM;
         end
         S_CSUM: if (rx_valid) begin
            if (rx_data == sum_q) begin
               state_d     = S_DONE;
               load_done_d = 1'b1;
               rows_d      = rows_sh_q;
               cols_d      = cols_sh_q;
               clue_cnt_d  = len_q[ADDR_W:0];
            end else begin
               state_d = S_ERR; load_err_d = 1'b1; err_code_d = 2'd3;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (timeout_hit) begin
         state_d = S_ERR; load_err_d = 1'b1; err_code_d = 2'd0;
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rows_sh_q   <= '0;
         cols_sh_q   <= '0;
         sum_q       <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rows_q      <= '0;
         cols_q      <= '0;
         clue_cnt_q  <= '0;
         busy_q      <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         err_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         rows_sh_q   <= rows_sh_d;
         cols_sh_q   <= cols_sh_d;
         sum_q       <= sum_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rows_q      <= rows_d;
         cols_q      <= cols_d;
         clue_cnt_q  <= clue_cnt_d;
         busy_q      <= busy_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign rows      = rows_q;
   assign cols      = cols_q;
   assign clue_cnt  = clue_cnt_q;
   assign busy      = busy_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_puzzle_loader.sv
// Self-checking bench for puzzle_loader: vector table, hand sequences and random packets vs a packet-level model.
module tb_puzzle_loader;
   localparam int TB_TMO = 40;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [63:0] bytes;
      logic [3:0]  n;
      logic [1:0]  kind;   // 1 done, 2 err
      logic [1:0]  code;
      logic [7:0]  rows;
      logic [7:0]  cols;
      logic [8:0]  cnt;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       solver_rdy = 1'b1;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] rows;
   logic [7:0] cols;
   logic [8:0] clue_cnt;
   logic       busy;
   logic       load_done;
   logic       load_err;
   logic [1:0] err_code;

   always #5 clk = ~clk;

   puzzle_loader #(.MAX_DIM(15), .MAX_CLUES(256), .TIMEOUT_CYC(TB_TMO)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .solver_rdy(solver_rdy),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rows(rows), .cols(cols),
      .clue_cnt(clue_cnt), .busy(busy), .load_done(load_done), .load_err(load_err),
      .err_code(err_code)
   );

   int checks = 0;
   int errors = 0;
   int exp_rows = 0, exp_cols = 0, exp_cnt = 0;

   // Monitor: every RAM write and every done/err pulse cycle.
   logic [15:0] wr_q[$];
   int          done_tot = 0, err_tot = 0;
   int          last_code = 0;
   always @(negedge clk) begin
      if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
      if (load_done) done_tot++;
      if (load_err) begin
         err_tot++;
         last_code = int'(err_code);
      end
   end

   int wr_base, done_base, err_base;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic mark();
      @(posedge clk); #1;
      wr_base = wr_q.size(); done_base = done_tot; err_base = err_tot;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk); rx_valid = 1'b1; rx_data = b;
      @(negedge clk); rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input bq_t p, input int nsend, input int gapmax);
      mark();
      for (int i = 0; i < nsend; i++) send_byte(p[i], int'($urandom_range(0, gapmax)));
      settle();
   endtask

   // Packet-level reference: which byte ends the packet, its outcome, and how many clue writes occur.
   function automatic void model(input bq_t p, output int used, output int kind,
                                 output int code, output int nw);
      int r, c, n;
      logic [7:0] s;
      nw = 0; kind = 2; code = 0;
      r = int'(p[1]);
      if (r < 1 || r > 15) begin used = 2; code = 1; return; end
      c = int'(p[2]);
      if (c < 1 || c > 15) begin used = 3; code = 1; return; end
      n = int'(p[3]) * 256 + int'(p[4]);
      if (n < 1 || n > 256) begin used = 5; code = 2; return; end
      s = 8'd0;
      for (int i = 1; i <= 4 + n; i++) s = s + p[i];
      nw = n; used = 6 + n;
      if (p[5 + n] == s) begin kind = 1; code = 0; end
      else code = 3;
   endfunction

   task automatic check_pkt(input string tag, input bq_t p, input int ek, input int ec, input int nw);
      int nd, ne, ndw;
      nd = done_tot - done_base; ne = err_tot - err_base; ndw = wr_q.size() - wr_base;
      chk({tag, " done_pulses"}, nd, (ek == 1) ? 1 : 0);
      chk({tag, " err_pulses"}, ne, (ek == 2) ? 1 : 0);
      if (ek == 2) chk({tag, " err_code"}, last_code, ec);
      chk({tag, " rows"}, int'(rows), exp_rows);
      chk({tag, " cols"}, int'(cols), exp_cols);
      chk({tag, " clue_cnt"}, int'(clue_cnt), exp_cnt);
      chk({tag, " busy_after"}, int'(busy), 0);
      chk({tag, " n_writes"}, ndw, nw);
      for (int k = 0; k < ndw && k < nw; k++) begin
         chk({tag, " wr_addr"}, int'(wr_q[wr_base + k][15:8]), k);
         chk({tag, " wr_data"}, int'(wr_q[wr_base + k][7:0]), int'(p[5 + k]));
      end
      $display("%s: done=%0d err=%0d code=%0d writes=%0d rows=%0d cols=%0d clue_cnt=%0d",
               tag, nd, ne, last_code, ndw, rows, cols, clue_cnt);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vecs[9];
   bq_t  q;
   vec_t v;
   int   used, mk, mc, nw, n, sel, seen;
   logic [7:0] s;

   initial begin
      vecs[0] = '{bytes:64'hA5_03_02_00_02_11_22_3A, n:4'd8, kind:2'd1, code:2'd0, rows:8'd3,  cols:8'd2,  cnt:9'd2};
      vecs[1] = '{bytes:64'hA5_03_02_00_02_11_22_36, n:4'd8, kind:2'd2, code:2'd3, rows:8'd3,  cols:8'd2,  cnt:9'd2};
      vecs[2] = '{bytes:64'hA5_00_00_00_00_00_00_00, n:4'd2, kind:2'd2, code:2'd1, rows:8'd3,  cols:8'd2,  cnt:9'd2};
      vecs[3] = '{bytes:64'hA5_02_02_01_02_00_00_00, n:4'd5, kind:2'd2, code:2'd2, rows:8'd3,  cols:8'd2,  cnt:9'd2};
      vecs[4] = '{bytes:64'hA5_01_0F_00_01_7E_8F_00, n:4'd7, kind:2'd1, code:2'd0, rows:8'd1,  cols:8'd15, cnt:9'd1};
      vecs[5] = '{bytes:64'hA5_10_00_00_00_00_00_00, n:4'd2, kind:2'd2, code:2'd1, rows:8'd1,  cols:8'd15, cnt:9'd1};
      vecs[6] = '{bytes:64'hA5_02_10_00_00_00_00_00, n:4'd3, kind:2'd2, code:2'd1, rows:8'd1,  cols:8'd15, cnt:9'd1};
      vecs[7] = '{bytes:64'hA5_02_02_00_00_00_00_00, n:4'd5, kind:2'd2, code:2'd2, rows:8'd1,  cols:8'd15, cnt:9'd1};
      vecs[8] = '{bytes:64'hA5_01_01_01_01_00_00_00, n:4'd5, kind:2'd2, code:2'd2, rows:8'd1,  cols:8'd15, cnt:9'd1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst mem_we", int'(mem_we), 0);
      chk("rst mem_addr", int'(mem_addr), 0);
      chk("rst mem_wdata", int'(mem_wdata), 0);
      chk("rst rows", int'(rows), 0);
      chk("rst cols", int'(cols), 0);
      chk("rst clue_cnt", int'(clue_cnt), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst load_done", int'(load_done), 0);
      chk("rst load_err", int'(load_err), 0);
      chk("rst err_code", int'(err_code), 0);
      @(negedge clk); rst = 1'b0;

      // Vector table
      for (int vi = 0; vi < 9; vi++) begin
         v = vecs[vi];
         q.delete();
         for (int i = 0; i < int'(v.n); i++) q.push_back(v.bytes[63 - 8*i -: 8]);
         model(q, used, mk, mc, nw);
         send_pkt(q, int'(v.n), 1);
         exp_rows = int'(v.rows); exp_cols = int'(v.cols); exp_cnt = int'(v.cnt);
         check_pkt($sformatf("vec%0d", vi), q, int'(v.kind), int'(v.code), nw);
      end

      // solver_rdy gating in IDLE; a drop mid-packet must not abort
      mark();
      solver_rdy = 1'b0;
      q.delete(); q = '{8'h00, 8'hFF, 8'hA5};
      for (int i = 0; i < 3; i++) begin
         send_byte(q[i], 0);
         @(posedge clk); #1;
         chk("rdy0 busy", int'(busy), 0);
      end
      solver_rdy = 1'b1;
      send_byte(8'hA5, 0);
      @(posedge clk); #1;
      chk("rdy1 busy", int'(busy), 1);
      solver_rdy = 1'b0;
      q.delete(); q = '{8'hA5, 8'h03, 8'h02, 8'h00, 8'h02, 8'h11, 8'h22, 8'h3A};
      for (int i = 1; i < 8; i++) send_byte(q[i], 1);
      settle();
      solver_rdy = 1'b1;
      exp_rows = 3; exp_cols = 2; exp_cnt = 2;
      check_pkt("rdy_drop", q, 1, 0, 2);

      // Stall mid-packet
      mark();
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
`ifdef PUZZLE_LOADER_TIMEOUT_EN
      seen = -1;
      for (int i = 1; i <= TB_TMO + 20 && seen < 0; i++) begin
         @(posedge clk); #1;
         if (load_err) begin
            seen = i;
            chk("timeout err_code", int'(err_code), 0);
         end
      end
      chk("timeout latency", seen, TB_TMO);
      settle();
      check_pkt("timeout", q, 2, 0, 0);
`else
      repeat (3 * TB_TMO) @(posedge clk);
      #1;
      chk("stall busy", int'(busy), 1);
      chk("stall err_pulses", err_tot - err_base, 0);
      for (int i = 2; i < 8; i++) send_byte(q[i], 0);
      settle();
      check_pkt("stall_resume", q, 1, 0, 2);
`endif

      // Reset after LEN_LO, then a clean packet
      mark();
      for (int i = 0; i < 5; i++) send_byte(q[i], 0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst busy", int'(busy), 0);
      chk("midrst rows", int'(rows), 0);
      chk("midrst clue_cnt", int'(clue_cnt), 0);
      chk("midrst mem_we", int'(mem_we), 0);
      @(negedge clk); rst = 1'b0;
      settle();
      chk("midrst pulses", (done_tot - done_base) + (err_tot - err_base), 0);
      exp_rows = 0; exp_cols = 0; exp_cnt = 0;
      q.delete(); q = '{8'hA5, 8'h01, 8'h0F, 8'h00, 8'h01, 8'h7E, 8'h8F};
      send_pkt(q, 7, 1);
      exp_rows = 1; exp_cols = 15; exp_cnt = 1;
      check_pkt("post_rst", q, 1, 0, 1);

      // Largest legal packet: 15x15 with 256 clues
      q.delete(); q = '{8'hA5, 8'h0F, 8'h0F, 8'h01, 8'h00};
      s = 8'h0F + 8'h0F + 8'h01;
      for (int k = 0; k < 256; k++) begin
         q.push_back(8'(k * 7 + 3));
         s = s + 8'(k * 7 + 3);
      end
      q.push_back(s);
      send_pkt(q, 262, 0);
      exp_rows = 15; exp_cols = 15; exp_cnt = 256;
      check_pkt("max_pkt", q, 1, 0, 256);

      // Random packets against the model
      for (int t = 0; t < 40; t++) begin
         q.delete();
         q.push_back(8'hA5);
         for (int j = 0; j < 2; j++) begin
            sel = int'($urandom_range(0, 11));
            q.push_back((sel == 0) ? 8'd0 : (sel == 1) ? 8'($urandom_range(16, 255))
                                                       : 8'($urandom_range(1, 15)));
         end
         sel = int'($urandom_range(0, 19));
         n = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(257, 600)) :
             (sel == 2) ? 256 : int'($urandom_range(1, 24));
         q.push_back(8'(n >> 8));
         q.push_back(8'(n));
         if (n >= 1 && n <= 256) begin
            s = q[1] + q[2] + q[3] + q[4];
            for (int k = 0; k < n; k++) begin
               q.push_back(8'($urandom_range(0, 255)));
               s = s + q[5 + k];
            end
            if ($urandom_range(0, 4) == 0) s = s ^ 8'($urandom_range(1, 255));
            q.push_back(s);
         end
         model(q, used, mk, mc, nw);
         if (mk == 1) begin
            exp_rows = int'(q[1]); exp_cols = int'(q[2]); exp_cnt = n;
         end
         send_pkt(q, used, 3);
         check_pkt($sformatf("rnd%0d", t), q, mk, mc, nw);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
